seq_mult_acc: RTL and testbench
===============================

SEQ_MULT_ACC -- requirements
Module: seq_mult_acc

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand width in bits (W >= 2).
REQ-002 SHALL have parameter ACC_W, default 2*W+4, meaning accumulator width; elaboration SHALL fail if ACC_W < 2*W.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, request is valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have port in_x, input, W, multiplicand.
REQ-008 SHALL have port in_y, input, W, multiplier.
REQ-009 SHALL have port in_signed, input, 1, where 1 means operands, product and accumulator are two's complement and 0 means unsigned.
REQ-010 SHALL have port in_acc, input, 1, where 1 means add the product to the accumulator and 0 means load the accumulator with the product.
REQ-011 SHALL have port out_valid, output, 1, result is valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port out_prod, output, 2*W, exact product.
REQ-014 SHALL have port out_acc, output, ACC_W, accumulator value after this operation.
REQ-015 SHALL have port out_ovf, output, 1, this operation's accumulate wrapped.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, FIX and DONE.
REQ-017 in_ready SHALL be high only in IDLE; a request is accepted on an edge where in_valid && in_ready, and that edge latches in_x, in_y, in_signed and in_acc and enters BUSY.
REQ-018 BUSY SHALL perform one shift-add partial-product step per cycle for exactly W cycles using a down-counter, then go to FIX.
REQ-019 FIX SHALL take one cycle that applies the signed correction (two's-complement product of the signed interpretations), updates the accumulator, then enters DONE.
REQ-020 out_valid SHALL be high only in DONE, first visible after the (W+1)th edge following the accepting edge.
REQ-021 In DONE, out_prod, out_acc and out_ovf SHALL hold stable until an edge with out_ready high; that edge SHALL return the FSM to IDLE.
REQ-022 No request SHALL be accepted on the DONE-exit edge; minimum issue period SHALL be W+3 cycles.
REQ-023 Input changes while not in IDLE SHALL have no effect.
REQ-024 Product extension to ACC_W SHALL be sign extension when in_signed=1 and zero extension otherwise.
REQ-025 in_acc=0 SHALL set acc to the extended product and set out_ovf to 0.
REQ-026 in_acc=1 SHALL set acc to acc plus the extended product, modulo 2^ACC_W.
REQ-027 When in_acc=1, out_ovf SHALL be the unsigned carry-out if in_signed=0, or signed overflow if in_signed=1.
REQ-028 out_ovf SHALL be per operation, not sticky.
REQ-029 The accumulator SHALL persist across operations and change only in FIX.

Reset
REQ-030 rst_n low SHALL immediately force state to IDLE, clear the counter and all datapath registers, and set accumulator=0, out_valid=0, out_prod=0, out_acc=0, out_ovf=0 and in_ready=1, regardless of current state (including mid-BUSY or DONE).
REQ-031 After rst_n deasserts, the first accepting edge SHALL behave identically to a first operation after power-up; an aborted operation SHALL leave no trace.

Structure
REQ-032 A shared package mult_pkg SHALL hold the FSM state enum typedef and the extension helper function; W and ACC_W remain module parameters.
REQ-033 The shift-add datapath (partial product, multiplier shift register and counter) SHALL be one sub-module, seq_mult_core; seq_mult_acc SHALL own the FSM, the signed fix-up, the accumulator and the handshake.

Verification (W=8, ACC_W=20 unless stated)
REQ-034 Unsigned 255*255 with in_acc=0 -> out_prod=0xFE01, out_acc=0x0FE01, out_ovf=0, and out_valid first high after the 9th edge post-accept.
REQ-035 Signed (-128)*(-128) -> out_prod=0x4000; signed (-1)*127 with in_acc=0 -> out_prod=0xFF81 and out_acc=0xFFF81.
REQ-036 Unsigned 255*255 load followed by 16 accumulates -> ops 2..16 have out_ovf=0; the 17th op has out_acc=56849 and out_ovf=1.
REQ-037 out_ready held low 5 cycles in DONE while in_valid=1 -> outputs stable, in_ready=0, no request accepted; release -> IDLE, and the pending request is accepted on a later edge.
REQ-038 rst_n pulsed low mid-BUSY -> all outputs 0 and in_ready=1 immediately; then 3*4 with in_acc=1 -> out_acc=12.
REQ-039 W=4: exhaustive sweep of all x,y in both modes with in_acc=0 against a behavioural model -> zero mismatches; the bench SHALL stop on the first mismatch.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and product-extension helper for seq_mult_acc.
package mult_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
    localparam int MAX_W = 128;
    // Extends the low w bits of v to MAX_W bits, sign-filling when sgn is set.
    function automatic logic [MAX_W-1:0] ext(input logic [MAX_W-1:0] v, input int w, input logic sgn);
        logic [MAX_W-1:0] r;
        for (int i = 0; i < MAX_W; i++) r[i] = (i < w) ? v[i] : (sgn & v[w-1]);
        return r;
    endfunction
endpackage

// File: rtl/seq_mult_core.sv
// seq_mult_core: unsigned shift-add multiplier, one partial-product step per enabled cycle.
module seq_mult_core #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
    input  logic           i_step,
    input  logic [W-1:0]   i_x,
    input  logic [W-1:0]   i_y,
    output logic [2*W-1:0] o_prod,
    output logic           o_last
);
    localparam int CW = $clog2(W + 1);
    logic [W-1:0]   r_mcand;
    logic [W-1:0]   r_mplier;
    logic [2*W-1:0] r_pp;
    logic [CW-1:0]  r_cnt;
    logic [W:0]     w_sum;
    // Add into the upper half, then shift the whole partial product right.
    assign w_sum  = {1'b0, r_pp[2*W-1:W]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign o_prod = r_pp;
    assign o_last = r_cnt == CW'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_pp     <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= i_x;
            r_mplier <= i_y;
            r_pp     <= '0;
            r_cnt    <= CW'(W);
        end else if (i_step && r_cnt != '0) begin
            r_pp     <= {w_sum, r_pp[W-1:1]};
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
        end
    end
endmodule

// File: rtl/seq_mult_acc.sv
// seq_mult_acc: sequential signed/unsigned multiply-accumulate with valid/ready handshakes.
module seq_mult_acc
    import mult_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 2*W + 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_signed,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_prod,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);
    if (W < 2) begin : g_bad_w
        $error("seq_mult_acc: W must be >= 2");
    end
    if (ACC_W < 2*W || ACC_W > MAX_W) begin : g_bad_acc
        $error("seq_mult_acc: ACC_W must be in [2*W, MAX_W]");
    end
    state_t           r_state, w_next;
    logic [W-1:0]     r_x, r_y;
    logic             r_sgn, r_accm, r_ovf;
    logic [ACC_W-1:0] r_acc, w_ext;
    logic [2*W-1:0]   r_prod, w_uprod, w_fix;
    logic [ACC_W:0]   w_sum;
    logic             w_accept, w_last, w_sovf;
    assign w_accept = in_valid && in_ready;
    seq_mult_core #(.W(W)) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept),
        .i_step  (r_state == BUSY),
        .i_x     (in_x),
        .i_y     (in_y),
        .o_prod  (w_uprod),
        .o_last  (w_last)
    );
    // A negative operand's MSB weighs -2^(W-1), so subtract the other operand shifted by W.
    assign w_fix  = w_uprod - ((r_sgn && r_x[W-1]) ? {r_y, {W{1'b0}}} : '0)
                            - ((r_sgn && r_y[W-1]) ? {r_x, {W{1'b0}}} : '0);
    assign w_ext  = ACC_W'(ext(MAX_W'(w_fix), 2*W, r_sgn));
    assign w_sum  = {1'b0, r_acc} + {1'b0, w_ext};
    assign w_sovf = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE) ? (in_valid ? BUSY : IDLE) :
                 (r_state == BUSY) ? (w_last ? FIX : BUSY) :
                 (r_state == FIX)  ? DONE :
                 (out_ready ? IDLE : DONE);
    end
    always_comb begin
        in_ready  = r_state == IDLE;
        out_valid = r_state == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_sgn  <= 1'b0;
            r_accm <= 1'b0;
            r_acc  <= '0;
            r_prod <= '0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_x    <= in_x;
            r_y    <= in_y;
            r_sgn  <= in_signed;
            r_accm <= in_acc;
        end else if (r_state == FIX) begin
            r_prod <= w_fix;
            r_acc  <= r_accm ? w_sum[ACC_W-1:0] : w_ext;
            r_ovf  <= r_accm && (r_sgn ? w_sovf : w_sum[ACC_W]);
        end
    end
    assign out_prod = r_prod;
    assign out_acc  = r_acc;
    assign out_ovf  = r_ovf;
endmodule

// File: tb/tb_seq_mult_acc.sv
// tb_seq_mult_acc: directed self-checking bench for seq_mult_acc (W=8 and an exhaustive W=4 sweep).
module tb_seq_mult_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv, ir, isg, iac, ov, ordy, oovf;
    logic [7:0]  ix, iy;
    logic [15:0] oprod;
    logic [19:0] oacc;

    logic        v4, r4, s4, a4, ov4, ordy4, ovf4;
    logic [3:0]  x4, y4;
    logic [7:0]  p4;
    logic [11:0] acc4;

    seq_mult_acc #(.W(8), .ACC_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_x(ix), .in_y(iy),
        .in_signed(isg), .in_acc(iac), .out_valid(ov), .out_ready(ordy),
        .out_prod(oprod), .out_acc(oacc), .out_ovf(oovf)
    );

    seq_mult_acc #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_x(x4), .in_y(y4),
        .in_signed(s4), .in_acc(a4), .out_valid(ov4), .out_ready(ordy4),
        .out_prod(p4), .out_acc(acc4), .out_ovf(ovf4)
    );

    int checks = 0;
    int failures = 0;
    int lat, n;
    logic [15:0] rp;
    logic [19:0] ra;
    logic        ro;
    logic [7:0]  rp4;
    logic [11:0] ra4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s, input logic a);
        int k;
        @(negedge clk);
        ix = x; iy = y; isg = s; iac = a; iv = 1'b1;
        k = 0;
        while (!ir && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < 50) begin @(negedge clk); lat++; end
        check("op8_timeout", ov, 1);
        rp = oprod; ra = oacc; ro = oovf;
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic s);
        int k;
        @(negedge clk);
        x4 = x; y4 = y; s4 = s; a4 = 1'b0; v4 = 1'b1;
        k = 0;
        while (!r4 && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        v4 = 1'b0;
        k = 0;
        while (!ov4 && k < 50) begin @(negedge clk); k++; end
        check("op4_timeout", ov4, 1);
        rp4 = p4; ra4 = acc4;
        ordy4 = 1'b1;
        @(negedge clk);
        ordy4 = 1'b0;
    endtask

    initial begin
        iv = 0; ix = 0; iy = 0; isg = 0; iac = 0; ordy = 0;
        v4 = 0; x4 = 0; y4 = 0; s4 = 0; a4 = 0; ordy4 = 0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", ir, 1);
        check("rst_out_valid", ov, 0);
        check("rst_prod", oprod, 0);
        check("rst_acc", oacc, 0);
        check("rst_ovf", oovf, 0);
        rst_n = 1'b1;

        op8(8'd255, 8'd255, 1'b0, 1'b0);
        check("u255_prod", rp, 16'hFE01);
        check("u255_acc", ra, 20'h0FE01);
        check("u255_ovf", ro, 0);
        check("u255_latency", lat, 9);

        op8(8'h80, 8'h80, 1'b1, 1'b0);
        check("s_m128sq_prod", rp, 16'h4000);
        check("s_m128sq_acc", ra, 20'h04000);
        op8(8'hFF, 8'h7F, 1'b1, 1'b0);
        check("s_m1x127_prod", rp, 16'hFF81);
        check("s_m1x127_acc", ra, 20'hFFF81);
        check("s_m1x127_ovf", ro, 0);
        op8(8'd1, 8'd127, 1'b1, 1'b1);
        check("s_acc_zero", ra, 20'h00000);
        check("s_acc_noovf", ro, 0);

        op8(8'd255, 8'd255, 1'b0, 1'b0);
        for (int i = 2; i <= 16; i++) begin
            op8(8'd255, 8'd255, 1'b0, 1'b1);
            check("acc_seq_ovf", ro, 0);
        end
        check("acc16_val", ra, 20'd1040400);
        op8(8'd255, 8'd255, 1'b0, 1'b1);
        check("acc17_val", ra, 20'd56849);
        check("acc17_ovf", ro, 1);
        op8(8'd0, 8'd0, 1'b0, 1'b1);
        check("ovf_not_sticky", ro, 0);
        check("acc_hold", ra, 20'd56849);

        @(negedge clk);
        ix = 8'd2; iy = 8'd3; isg = 0; iac = 0; iv = 1'b1;
        n = 0;
        while (!ir && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        ix = 8'd5; iy = 8'd7;
        n = 0;
        while (!ov && n < 50) begin @(negedge clk); n++; end
        check("hold_valid", ov, 1);
        for (int i = 0; i < 5; i++) begin
            check("hold_prod", oprod, 16'd6);
            check("hold_in_ready", ir, 0);
            check("hold_valid_stay", ov, 1);
            @(negedge clk);
        end
        check("hold_acc", oacc, 20'd6);
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        check("exit_in_ready", ir, 1);
        check("exit_out_valid", ov, 0);
        @(negedge clk);
        iv = 1'b0;
        check("pending_accepted", ir, 0);
        n = 0;
        while (!ov && n < 50) begin @(negedge clk); n++; end
        check("pending_prod", oprod, 16'd35);
        check("pending_acc", oacc, 20'd35);
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;

        @(negedge clk);
        ix = 8'd9; iy = 8'd9; isg = 0; iac = 1; iv = 1'b1;
        n = 0;
        while (!ir && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        iv = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", ir, 1);
        check("midrst_valid", ov, 0);
        check("midrst_prod", oprod, 0);
        check("midrst_acc", oacc, 0);
        check("midrst_ovf", oovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op8(8'd3, 8'd4, 1'b0, 1'b1);
        check("postrst_acc", ra, 20'd12);
        check("postrst_prod", rp, 16'd12);
        check("postrst_ovf", ro, 0);

        begin : sweep
            for (int s = 0; s < 2; s++) begin
                for (int x = 0; x < 16; x++) begin
                    for (int y = 0; y < 16; y++) begin
                        logic [3:0] xx, yy;
                        int xi, yi, p, f0;
                        logic [7:0] ep;
                        logic [11:0] ea;
                        xx = 4'(x); yy = 4'(y);
                        xi = (s != 0) ? int'($signed(xx)) : int'(xx);
                        yi = (s != 0) ? int'($signed(yy)) : int'(yy);
                        p = xi * yi;
                        ep = 8'(p);
                        ea = 12'(p);
                        op4(xx, yy, s[0]);
                        f0 = failures;
                        check("sweep_prod", rp4, ep);
                        check("sweep_acc", ra4, ea);
                        if (failures != f0) disable sweep;
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
